// File: rtl/logwr.sv
// Hardware log writer: turns event records into complete log-buffer entries over a simple bus,
// keeping its own ring head and preserving the software-owned read index.
//
// state | meaning
// IDLE  | waiting for an event; evt_rdy follows en
// RDIX  | reading the buffer index word to capture the read index (get)
// WRIX  | writing {head, get}: sets put, keeps get, rewinds slot pointers
// DATA  | writing one byte per slot, record bytes then zero padding
// DONE  | entry complete, advance ring head
module logwr #(
  parameter  int NUM_ENTRIES = 32,
  parameter  int NUM_SLOTS   = 64,
  parameter  int REC_BYTES   = 8,
  localparam int LEN_W       = $clog2(REC_BYTES + 1),
  localparam int HEAD_W      = $clog2(NUM_ENTRIES),
  localparam int SLOT_W      = $clog2(NUM_SLOTS),
  localparam int BIDX_W      = $clog2(REC_BYTES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_evt_vld,
  output logic                   o_evt_rdy,
  input  logic [8*REC_BYTES-1:0] i_evt_data,
  input  logic [LEN_W-1:0]       i_evt_len,
  output logic                   o_m_stb,
  output logic                   o_m_we,
  output logic                   o_m_addr,
  output logic [31:0]            o_m_dout,
  input  logic [31:0]            i_m_din,
  input  logic                   i_m_ack,
  output logic                   o_busy,
  output logic [HEAD_W-1:0]      o_head
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDIX,
    S_WRIX,
    S_DATA,
    S_DONE
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [HEAD_W-1:0]               r_head;
  logic [SLOT_W-1:0]               r_slot;
  logic [15:0]                     r_get;
  logic [REC_BYTES-1:0][7:0]       r_rec;
  logic [LEN_W-1:0]                r_len;

  logic                            w_accept;
  logic [LEN_W-1:0]                w_len_clamped;
  logic                            w_last_slot;
  logic                            w_in_record;
  logic [7:0]                      w_byte;
  logic [HEAD_W-1:0]               w_head_nxt;
  logic [15:0]                     w_unused_din;

  // Only the low half of the index word carries the read index.
  assign w_unused_din  = i_m_din[31:16];

  assign o_evt_rdy     = i_rst_n & i_en & (r_state == S_IDLE);
  assign w_accept      = i_evt_vld & o_evt_rdy;
  assign w_len_clamped = (i_evt_len > LEN_W'(REC_BYTES)) ? LEN_W'(REC_BYTES) : i_evt_len;
  assign w_last_slot   = (r_slot == SLOT_W'(NUM_SLOTS - 1));
  assign w_in_record   = (r_slot < SLOT_W'(r_len));
  assign w_byte        = w_in_record ? r_rec[r_slot[BIDX_W-1:0]] : 8'h00;
  assign w_head_nxt    = (r_head == HEAD_W'(NUM_ENTRIES - 1)) ? '0 : r_head + HEAD_W'(1);

  assign o_busy        = (r_state != S_IDLE);
  assign o_head        = r_head;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RDIX;
      S_RDIX: if (i_m_ack) w_state_nxt = S_WRIX;
      S_WRIX: if (i_m_ack) w_state_nxt = S_DATA;
      S_DATA: if (i_m_ack && w_last_slot) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decode purely from registered state, so they hold while ack is low.
  always_comb begin
    o_m_stb  = 1'b0;
    o_m_we   = 1'b0;
    o_m_addr = 1'b0;
    o_m_dout = 32'h0;
    case (r_state)
      S_RDIX: begin
        o_m_stb  = 1'b1;
        o_m_addr = 1'b1;
      end
      S_WRIX: begin
        o_m_stb  = 1'b1;
        o_m_we   = 1'b1;
        o_m_addr = 1'b1;
        o_m_dout = {16'(r_head), r_get};
      end
      S_DATA: begin
        o_m_stb  = 1'b1;
        o_m_we   = 1'b1;
        o_m_dout = {24'h0, w_byte};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_slot  <= '0;
      r_get   <= '0;
      r_rec   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rec <= i_evt_data;
            r_len <= w_len_clamped;
          end
        end
        S_RDIX: if (i_m_ack) r_get <= i_m_din[15:0];
        S_WRIX: if (i_m_ack) r_slot <= '0;
        S_DATA: begin
          if (i_m_ack) r_slot <= w_last_slot ? '0 : r_slot + SLOT_W'(1);
        end
        S_DONE: r_head <= w_head_nxt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logwr.sv
// Scoreboard bench for logwr: a bus/buffer model with optional stalls, expected transfers
// queued at stimulus time and popped by an independent monitor.
module tb_logwr;

  localparam int NE = 32;
  localparam int NS = 64;

  typedef struct packed {
    logic        we;
    logic        addr;
    logic [31:0] dout;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        evt_vld;
  logic        evt_rdy;
  logic [63:0] evt_data;
  logic [3:0]  evt_len;
  logic        m_stb, m_we, m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        m_ack;
  logic        busy;
  logic [4:0]  head;

  xfer_t       exp_q[$];
  xfer_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] buf_get = 16'd5;
  logic [15:0] buf_put = 16'd0;
  logic [15:0] sw_get  = 16'd5;
  int          model_head = 0;
  bit          stall_en = 1'b0;

  int          bus_data_cnt = 0;
  int          bus_left = 0;
  bit          bus_done_here = 1'b0;
  logic        bus_pstb = 1'b0, bus_pwe = 1'b0, bus_paddr = 1'b0, bus_pack = 1'b0;
  logic [2:0]  bus_snap_ctl;
  logic [31:0] bus_snap_dout;
  int          bus_pos;

  always #5 clk = ~clk;

  assign m_din = {16'hBEEF, buf_get};

  logwr dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_evt_vld(evt_vld), .o_evt_rdy(evt_rdy),
    .i_evt_data(evt_data), .i_evt_len(evt_len),
    .o_m_stb(m_stb), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_dout(m_dout),
    .i_m_din(m_din), .i_m_ack(m_ack),
    .o_busy(busy), .o_head(head)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_entry(input logic [63:0] d, input logic [3:0] len, input int put);
    int n;
    logic [7:0] b;
    n = (len > 4'd8) ? 8 : int'(len);
    exp_q.push_back(xfer_t'{we: 1'b0, addr: 1'b1, dout: 32'h0});
    exp_q.push_back(xfer_t'{we: 1'b1, addr: 1'b1, dout: {16'(put), sw_get}});
    for (int s = 0; s < NS; s++) begin
      b = 8'h00;
      if (s < n) b = d[8*s +: 8];
      exp_q.push_back(xfer_t'{we: 1'b1, addr: 1'b0, dout: {24'h0, b}});
    end
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!evt_rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!evt_rdy) begin
      checks++; errors++;
      $display("FAIL rdy_timeout: got rdy=0 expected rdy=1 within 400 cycles");
    end
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (busy && lat < 400);
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 400 cycles");
    end
  endtask

  task automatic accept(input logic [63:0] d, input logic [3:0] len);
    wait_rdy();
    evt_data = d;
    evt_len  = len;
    evt_vld  = 1'b1;
    push_entry(d, len, model_head % NE);
    @(posedge clk);
    #1 evt_vld = 1'b0;
  endtask

  task automatic send_event(input logic [63:0] d, input logic [3:0] len, output int lat);
    accept(d, len);
    wait_idle(lat);
    model_head = (model_head + 1) % NE;
  endtask

  // Buffer model: acks every strobe, optionally stalling 3 cycles at RDIX, WRIX and DATA slot 10.
  initial begin
    m_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus_data_cnt = 0; bus_left = 0; bus_done_here = 1'b0;
        bus_pstb = 1'b0; bus_pack = 1'b0;
        m_ack = 1'b1;
      end else begin
        if (bus_pstb && bus_pack) begin
          bus_done_here = 1'b0;
          if (bus_pwe && bus_paddr) bus_data_cnt = 0;
          else if (bus_pwe) bus_data_cnt++;
        end
        bus_pos = !m_stb ? -1 : (!m_we ? 0 : (m_addr ? 1 : 2 + bus_data_cnt));
        if (bus_left > 0) begin
          m_ack = 1'b0;
          bus_left--;
          chk("stall_ctl", 32'({m_stb, m_we, m_addr}), 32'(bus_snap_ctl));
          chk("stall_dout", m_dout, bus_snap_dout);
        end else if (stall_en && m_stb && !bus_done_here &&
                     (bus_pos == 0 || bus_pos == 1 || bus_pos == 12)) begin
          m_ack = 1'b0;
          bus_left = 2;
          bus_done_here = 1'b1;
          bus_snap_ctl = {m_stb, m_we, m_addr};
          bus_snap_dout = m_dout;
        end else begin
          m_ack = 1'b1;
        end
        bus_pstb = m_stb; bus_pwe = m_we; bus_paddr = m_addr; bus_pack = m_ack;
      end
    end
  end

  // Monitor: every completed transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_stb && m_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got we=%b addr=%b dout=%h expected no transfer",
                   m_we, m_addr, m_dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_ctl", 32'({m_we, m_addr}), 32'({mon_e.we, mon_e.addr}));
          chk("xfer_dout", m_dout, mon_e.dout);
        end
        if (m_we && m_addr) begin
          buf_put <= m_dout[31:16];
          buf_get <= m_dout[15:0];
        end
      end
      if (!m_stb) chk("idle_bus", m_dout | {30'h0, m_we, m_addr}, 32'h0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; en = 1'b1; evt_vld = 1'b0; evt_data = '0; evt_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_stb", 32'(m_stb), 32'h0);
    chk("rst_we_addr", 32'({m_we, m_addr}), 32'h0);
    chk("rst_dout", m_dout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_head", 32'(head), 32'h0);
    chk("rst_rdy", 32'(evt_rdy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(evt_rdy), 32'h1);

    // single event, full length
    send_event(64'h0807060504030201, 4'd8, lat);
    chk("lat_single", lat, 68);
    chk("head_single", 32'(head), 32'd1);
    chk("buf_get_kept", 32'(buf_get), 32'd5);
    chk("buf_put", 32'(buf_put), 32'd0);

    // short, clamped and empty records
    send_event(64'hA1B2C3D4E5F60718, 4'd3, lat);
    chk("lat_len3", lat, 68);
    send_event(64'h1122334455667788, 4'd15, lat);
    chk("lat_len15", lat, 68);
    send_event(64'hFFFFFFFFFFFFFFFF, 4'd0, lat);
    chk("head_after4", 32'(head), 32'd4);

    // backpressure: three 3-cycle stalls add 9 cycles
    stall_en = 1'b1;
    send_event(64'h0807060504030201, 4'd8, lat);
    stall_en = 1'b0;
    chk("lat_stalled", lat, 77);
    chk("head_stalled", 32'(head), 32'd5);

    // evt_vld held while busy: second event waits for IDLE
    accept(64'hCAFEBABE00000001, 4'd8);
    evt_data = 64'h00000000DEADBEEF;
    evt_len  = 4'd5;
    evt_vld  = 1'b1;
    push_entry(64'h00000000DEADBEEF, 4'd5, (model_head + 1) % NE);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) chk("rdy_while_busy", 32'(evt_rdy), 32'h0);
    end while (busy && lat < 400);
    chk("lat_first_of_pair", lat, 68);
    @(posedge clk);
    #1 evt_vld = 1'b0;
    wait_idle(lat);
    chk("lat_second_of_pair", lat, 68);
    model_head = (model_head + 2) % NE;
    chk("head_pair", 32'(head), 32'd7);

    // en low in IDLE ignores evt_vld
    @(negedge clk);
    en = 1'b0;
    evt_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("en0_busy", 32'(busy), 32'h0);
      chk("en0_rdy", 32'(evt_rdy), 32'h0);
    end
    evt_vld = 1'b0;
    en = 1'b1;

    // en dropped mid-entry: entry still completes
    accept(64'h0102030405060708, 4'd6);
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_idle(lat);
    model_head = (model_head + 1) % NE;
    chk("lat_en_drop", lat, 58);
    chk("rdy_en_low", 32'(evt_rdy), 32'h0);
    chk("head_en_drop", 32'(head), 32'd8);
    en = 1'b1;

    // reset at DATA slot 20
    accept(64'h8877665544332211, 4'd8);
    repeat (23) @(negedge clk);
    chk("slot20_strobe", 32'({m_stb, m_we, m_addr}), 32'b110);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_head = 0;
    @(negedge clk);
    chk("midrst_stb", 32'(m_stb), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_head", 32'(head), 32'h0);
    rst_n = 1'b1;

    // ring wrap: event 1 goes to entry 0, event 32 to entry 31, event 33 back to entry 0
    send_event(64'h0000000000C0FFEE, 4'd4, lat);
    chk("lat_after_rst", lat, 68);
    chk("head_after_rst", 32'(head), 32'd1);
    for (int i = 2; i <= 33; i++) begin
      send_event({32'(i), 32'(i * 3)}, 4'(i % 9), lat);
      if (i == 32) chk("head_wrap", 32'(head), 32'd0);
    end
    chk("head_final", 32'(head), 32'd1);
    chk("buf_put_final", 32'(buf_put), 32'd0);
    chk("buf_get_final", 32'(buf_get), 32'd5);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
